// File: rtl/hicore_tcm_ctrl_pkg.sv
// ============================================================================
// Module      : hicore_tcm_ctrl_pkg
// Description : Shared ICB widths, byte-offset helper and error encoding
//               for the hicore TCM controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hicore_tcm_ctrl_pkg;

    localparam int c_ICB_AW = 32;
    localparam int c_ICB_DW = 32;

    localparam logic c_RSP_OK  = 1'b0;
    localparam logic c_RSP_ERR = 1'b1;

    // Number of byte-offset address bits for a data bus of dw bits.
    function automatic int calc_off(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hicore_tcm_sram.sv
// ============================================================================
// Module      : hicore_tcm_sram
// Description : Behavioural single-port SRAM, byte enables, 1-cycle
//               registered read, no reset (vendor-macro replaceable).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hicore_tcm_sram #(
    parameter int DW        = 32,
    parameter int RAM_DEPTH = 14
) (
    input  logic                 clk,
    input  logic                 i_en,
    input  logic [DW/8-1:0]      i_we,
    input  logic [RAM_DEPTH-1:0] i_addr,
    input  logic [DW-1:0]        i_din,
    output logic [DW-1:0]        o_dout
);

    logic [DW-1:0] r_mem [0:(1<<RAM_DEPTH)-1];
    logic [DW-1:0] r_dout_q;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < DW/8; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_din[b*8 +: 8];
                end
            end
            r_dout_q <= r_mem[i_addr];
        end
    end

    assign o_dout = r_dout_q;

endmodule

`default_nettype wire

// File: rtl/hicore_tcm_ctrl.sv
// ============================================================================
// Module      : hicore_tcm_ctrl
// Description : ICB TCM controller with OUTSTAND-deep in-order response
//               buffer, credit flow control and address/alignment checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hicore_tcm_ctrl
    import hicore_tcm_ctrl_pkg::*;
#(
    parameter int             DW        = c_ICB_DW,
    parameter int             AW        = c_ICB_AW,
    parameter int             RAM_DEPTH = 14,
    parameter logic [AW-1:0]  BASE_ADDR = 32'h8000_0000,
    parameter int             OUTSTAND  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_icb_cmd_valid,
    output logic              mem_icb_cmd_ready,
    input  logic              mem_icb_cmd_read,
    input  logic [AW-1:0]     mem_icb_cmd_addr,
    input  logic [DW-1:0]     mem_icb_cmd_wdata,
    input  logic [DW/8-1:0]   mem_icb_cmd_wmask,
    output logic              mem_icb_rsp_valid,
    input  logic              mem_icb_rsp_ready,
    output logic              mem_icb_rsp_err,
    output logic [DW-1:0]     mem_icb_rsp_rdata
);

    localparam int c_OFF = calc_off(DW);
    localparam int c_BE  = DW / 8;
    localparam int c_CW  = $clog2(OUTSTAND + 1);
    localparam int c_PW  = (OUTSTAND > 1) ? $clog2(OUTSTAND) : 1;

    logic              w_cmd_hs, w_rsp_hs, w_err;
    logic              w_ram_en;
    logic [c_BE-1:0]   w_ram_we;
    logic [DW-1:0]     w_ram_dout, w_s1_rdata;
    logic              w_fifo_empty, w_push, w_pop;

    logic [c_CW-1:0]   r_cnt_q, w_cnt_d;
    logic              r_s1_vld_q, w_s1_vld_d;
    logic              r_s1_err_q, w_s1_err_d;
    logic              r_s1_read_q, w_s1_read_d;

    logic              r_fifo_err_q  [OUTSTAND];
    logic              w_fifo_err_d  [OUTSTAND];
    logic [DW-1:0]     r_fifo_data_q [OUTSTAND];
    logic [DW-1:0]     w_fifo_data_d [OUTSTAND];
    logic [c_PW-1:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic [c_PW-1:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [c_CW-1:0]   r_fcnt_q, w_fcnt_d;

    function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_PW'(OUTSTAND - 1)) ? '0 : p + c_PW'(1);
    endfunction

    // Ready depends only on the registered credit count, never on rsp_ready.
    assign mem_icb_cmd_ready = (r_cnt_q < c_CW'(OUTSTAND));
    assign w_cmd_hs          = mem_icb_cmd_valid & mem_icb_cmd_ready;

    assign w_err = (mem_icb_cmd_addr[AW-1:RAM_DEPTH+c_OFF] != BASE_ADDR[AW-1:RAM_DEPTH+c_OFF])
                 | (mem_icb_cmd_addr[c_OFF-1:0] != '0);

    assign w_ram_en = w_cmd_hs & ~w_err;
    assign w_ram_we = {c_BE{~mem_icb_cmd_read}} & mem_icb_cmd_wmask;

    hicore_tcm_sram #(
        .DW        (DW),
        .RAM_DEPTH (RAM_DEPTH)
    ) u_sram (
        .clk    (clk),
        .i_en   (w_ram_en),
        .i_we   (w_ram_we),
        .i_addr (mem_icb_cmd_addr[RAM_DEPTH+c_OFF-1:c_OFF]),
        .i_din  (mem_icb_cmd_wdata),
        .o_dout (w_ram_dout)
    );

    assign w_s1_rdata   = (r_s1_vld_q & r_s1_read_q & ~r_s1_err_q) ? w_ram_dout : '0;
    assign w_fifo_empty = (r_fcnt_q == '0);

    // The FIFO head always predates s1, so s1 bypasses only an empty FIFO.
    assign mem_icb_rsp_valid = ~w_fifo_empty | r_s1_vld_q;
    assign mem_icb_rsp_err   = w_fifo_empty ? (r_s1_vld_q & r_s1_err_q) : r_fifo_err_q[r_rd_ptr_q];
    assign mem_icb_rsp_rdata = w_fifo_empty ? w_s1_rdata : r_fifo_data_q[r_rd_ptr_q];

    assign w_rsp_hs = mem_icb_rsp_valid & mem_icb_rsp_ready;
    assign w_pop    = ~w_fifo_empty & mem_icb_rsp_ready;
    assign w_push   = r_s1_vld_q & ~(w_fifo_empty & mem_icb_rsp_ready);

    always_comb begin
        w_cnt_d     = r_cnt_q;
        w_s1_vld_d  = w_cmd_hs;
        w_s1_err_d  = (w_cmd_hs & w_err) ? c_RSP_ERR : c_RSP_OK;
        w_s1_read_d = w_cmd_hs & mem_icb_cmd_read;

        if (w_cmd_hs && !w_rsp_hs) begin
            w_cnt_d = r_cnt_q + c_CW'(1);
        end else if (!w_cmd_hs && w_rsp_hs) begin
            w_cnt_d = r_cnt_q - c_CW'(1);
        end
    end

    always_comb begin
        w_fifo_err_d  = r_fifo_err_q;
        w_fifo_data_d = r_fifo_data_q;
        w_rd_ptr_d    = r_rd_ptr_q;
        w_wr_ptr_d    = r_wr_ptr_q;
        w_fcnt_d      = r_fcnt_q;

        if (w_push) begin
            w_fifo_err_d[r_wr_ptr_q]  = r_s1_err_q;
            w_fifo_data_d[r_wr_ptr_q] = w_s1_rdata;
            w_wr_ptr_d                = ptr_inc(r_wr_ptr_q);
        end
        if (w_pop) begin
            w_rd_ptr_d = ptr_inc(r_rd_ptr_q);
        end
        if (w_push && !w_pop) begin
            w_fcnt_d = r_fcnt_q + c_CW'(1);
        end else if (!w_push && w_pop) begin
            w_fcnt_d = r_fcnt_q - c_CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_q     <= '0;
            r_s1_vld_q  <= 1'b0;
            r_s1_err_q  <= 1'b0;
            r_s1_read_q <= 1'b0;
            r_rd_ptr_q  <= '0;
            r_wr_ptr_q  <= '0;
            r_fcnt_q    <= '0;
            for (int i = 0; i < OUTSTAND; i++) begin
                r_fifo_err_q[i]  <= 1'b0;
                r_fifo_data_q[i] <= '0;
            end
        end else begin
            r_cnt_q       <= w_cnt_d;
            r_s1_vld_q    <= w_s1_vld_d;
            r_s1_err_q    <= w_s1_err_d;
            r_s1_read_q   <= w_s1_read_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_fcnt_q      <= w_fcnt_d;
            r_fifo_err_q  <= w_fifo_err_d;
            r_fifo_data_q <= w_fifo_data_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hicore_tcm_ctrl.sv
// ============================================================================
// Module      : tb_hicore_tcm_ctrl
// Description : Self-checking bench: directed vector table, corner sequences
//               and randomized traffic against a queue-based memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hicore_tcm_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q [$];
    logic [31:0] mdl [int unsigned];

    typedef struct {
        string       name;
        logic        read;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [$];

    hicore_tcm_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .mem_icb_cmd_valid (cmd_valid),
        .mem_icb_cmd_ready (cmd_ready),
        .mem_icb_cmd_read  (cmd_read),
        .mem_icb_cmd_addr  (cmd_addr),
        .mem_icb_cmd_wdata (cmd_wdata),
        .mem_icb_cmd_wmask (cmd_wmask),
        .mem_icb_rsp_valid (rsp_valid),
        .mem_icb_rsp_ready (rsp_ready),
        .mem_icb_rsp_err   (rsp_err),
        .mem_icb_rsp_rdata (rsp_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: a command accepted on an edge answers at the next edge's
    // window; the answer reflects memory as it was just before that accept.
    task automatic model_accept();
        logic        e;
        int unsigned idx;
        logic [31:0] w;
        e   = (cmd_addr[31:16] != 16'h8000) || (cmd_addr[1:0] != 2'b00);
        idx = int'(cmd_addr[15:2]);
        if (e) begin
            exp_q.push_back({1'b1, 32'h0});
        end else if (cmd_read) begin
            exp_q.push_back({1'b0, mdl.exists(idx) ? mdl[idx] : 32'hxxxx_xxxx});
        end else begin
            w = mdl.exists(idx) ? mdl[idx] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (cmd_wmask[b]) w[b*8 +: 8] = cmd_wdata[b*8 +: 8];
            mdl[idx] = w;
            exp_q.push_back({1'b0, 32'h0});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("cmd_ready", cmd_ready, exp_q.size() < 4);
        chk("rsp_valid", rsp_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("rsp_err", rsp_err, exp_q[0][32]);
            chk("rsp_rdata", rsp_rdata, exp_q[0][31:0]);
        end else begin
            chk("idle_rsp_zero", {rsp_err, rsp_rdata}, 0);
        end
        if (rsp_valid && rsp_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (cmd_valid && cmd_ready) model_accept();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk({nm, "_drain_pending"}, exp_q.size(), 0);
    endtask

    task automatic issue(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] m);
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_wmask = m;
    endtask

    task automatic single_op(input vec_t v);
        issue(v.read, v.addr, v.wdata, v.wmask);
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk({v.name, "_valid"}, rsp_valid, 1);
        chk({v.name, "_err"}, rsp_err, v.exp_err);
        chk({v.name, "_rdata"}, rsp_rdata, v.exp_rdata);
        tick();
    endtask

    function automatic vec_t mk(input string nm, input logic rd, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] m,
                                input logic ee, input logic [31:0] er);
        vec_t v;
        v.name = nm; v.read = rd; v.addr = a; v.wdata = wd; v.wmask = m;
        v.exp_err = ee; v.exp_rdata = er;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wmask = '0;
        rsp_ready = 1'b0;

        vecs.push_back(mk("w_word0",      0, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 32'h0));
        vecs.push_back(mk("w_word4",      0, 32'h8000_0010, 32'h1122_3344, 4'hF, 0, 32'h0));
        vecs.push_back(mk("r_word4",      1, 32'h8000_0010, 32'h0,         4'hF, 0, 32'h1122_3344));
        vecs.push_back(mk("w_byte1",      0, 32'h8000_0010, 32'hAABB_CCDD, 4'b0010, 0, 32'h0));
        vecs.push_back(mk("r_merged",     1, 32'h8000_0010, 32'h0,         4'h0, 0, 32'h1122_CC44));
        vecs.push_back(mk("r_outwin",     1, 32'h9000_0000, 32'h0,         4'h0, 1, 32'h0));
        vecs.push_back(mk("w_misalign",   0, 32'h8000_0002, 32'hFFFF_FFFF, 4'hF, 1, 32'h0));
        vecs.push_back(mk("r_word0_kept", 1, 32'h8000_0000, 32'h0,         4'h0, 0, 32'hCAFE_F00D));
        vecs.push_back(mk("w_mask0",      0, 32'h8000_0000, 32'h0000_0000, 4'h0, 0, 32'h0));
        vecs.push_back(mk("r_mask0_kept", 1, 32'h8000_0000, 32'h0,         4'h0, 0, 32'hCAFE_F00D));
        vecs.push_back(mk("w_lastword",   0, 32'h8000_FFFC, 32'h0BAD_BEEF, 4'hF, 0, 32'h0));
        vecs.push_back(mk("r_lastword",   1, 32'h8000_FFFC, 32'h0,         4'h0, 0, 32'h0BAD_BEEF));
        vecs.push_back(mk("r_above_win",  1, 32'h8001_0000, 32'h0,         4'h0, 1, 32'h0));
        vecs.push_back(mk("r_below_win",  1, 32'h7FFF_FFFC, 32'h0,         4'h0, 1, 32'h0));
        vecs.push_back(mk("r_misalign",   1, 32'h8000_0011, 32'h0,         4'h0, 1, 32'h0));

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_cmd_ready", cmd_ready, 1);

        foreach (vecs[i]) single_op(vecs[i]);

        // Fill 16 words back to back.
        rsp_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            issue(1'b0, 32'h8000_0000 + 32'(k * 4), 32'h1000_0000 + 32'(k) * 32'h0101_0101, 4'hF);
            tick();
        end
        drain("fill");

        // Back-to-back reads, one response per cycle.
        for (int k = 0; k < 4; k++) begin
            issue(1'b1, 32'h8000_0000 + 32'(k * 4), 32'h0, 4'h0);
            tick();
            chk("b2b_cmd_ready", cmd_ready, 1);
            chk("b2b_rsp_valid", rsp_valid, 1);
        end
        drain("b2b");

        // Credit exhaustion and recovery.
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            issue(1'b1, 32'h8000_0000 + 32'(k * 4), 32'h0, 4'h0);
            tick();
        end
        chk("credit_full_not_ready", cmd_ready, 0);
        tick();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("credit_ready_back", cmd_ready, 1);
        drain("credit");

        // Asynchronous reset with responses outstanding.
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            issue(1'b1, 32'h8000_0000 + 32'(k * 4), 32'h0, 4'h0);
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_rsp_valid_after", rsp_valid, 0);
        @(posedge clk);
        #1;

        // Write then read the same word next cycle, rsp_ready toggling.
        rsp_ready = 1'b1;
        issue(1'b0, 32'h8000_0020, 32'h5A5A_5A5A, 4'hF);
        tick();
        rsp_ready = 1'b0;
        issue(1'b1, 32'h8000_0020, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            rsp_ready = ~rsp_ready;
            tick();
        end
        chk("raw_toggle_pending", exp_q.size(), 0);
        single_op(mk("raw_reread", 1, 32'h8000_0020, 32'h0, 4'h0, 0, 32'h5A5A_5A5A));

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int unsigned k;
            k = $urandom_range(0, 19);
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_read  = 1'($urandom_range(0, 1));
            if (k < 16)       cmd_addr = 32'h8000_0000 + k * 4;
            else if (k == 16) cmd_addr = 32'h8000_0000 + $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
            else if (k == 17) cmd_addr = 32'h9000_0000 + $urandom_range(0, 255) * 4;
            else if (k == 18) cmd_addr = 32'h8001_0000;
            else              cmd_addr = 32'h7FFF_FFFC;
            cmd_wdata = $urandom();
            cmd_wmask = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
